// File: rtl/featurize_pkg.sv
// Shared types and widths for the featurize path blocks.
package featurize_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      EMIT   = 2'd2
   } split_state_t;

endpackage

// File: rtl/split_samples_if.sv
// Upstream sum input and downstream per-sample output, both ready/valid.
// The slave modport is the split_samples block; master is whoever drives it.
interface split_samples_if;
   import featurize_pkg::*;

   logic [DATA_W-1:0] i_data;
   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              o_last;
   logic              i_ready;

   modport master (
      output i_data, i_valid, i_ready,
      input  o_ready, o_data, o_valid, o_last
   );

   modport slave (
      input  i_data, i_valid, i_ready,
      output o_ready, o_data, o_valid, o_last
   );

endinterface

// File: rtl/restoring_div8.sv
// 8-bit sequential restoring divider, one quotient bit per cycle, MSB first.
// start (while idle) loads the operands; 8 iteration cycles follow. done is
// high during the final iteration cycle, so quotient/remainder are valid from
// the next cycle on and hold until the next start.
module restoring_div8
   import featurize_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   logic [DATA_W-1:0] rem;     // partial remainder (always < divisor)
   logic [DATA_W-1:0] qreg;    // dividend bits shift out, quotient bits shift in
   logic [2:0]        iter;
   logic [DATA_W:0]   trial;   // remainder shifted left with next dividend bit
   logic              fits;
   logic [DATA_W-1:0] diff;

   assign trial = {rem, qreg[DATA_W-1]};
   assign fits  = (trial >= {1'b0, divisor});
   // When fits, trial - divisor < divisor, so 8 bits hold it exactly.
   assign diff  = trial[DATA_W-1:0] - divisor;
   assign done  = busy && (iter == 3'd7);

   assign quotient  = qreg;
   assign remainder = rem;

   // Load on start, then one restoring step per cycle for 8 cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem  <= '0;
         qreg <= '0;
         iter <= '0;
         busy <= 1'b0;
      end else if (start && !busy) begin
         rem  <= '0;
         qreg <= dividend;
         iter <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         rem  <= fits ? diff : trial[DATA_W-1:0];
         qreg <= {qreg[DATA_W-2:0], fits};
         iter <= iter + 3'd1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/split_samples.sv
// Re-expands one epoch sum S into SAMPLES per-sample values: the first
// S % SAMPLES samples carry q+1, the rest carry q, where q = S / SAMPLES,
// so the group total is exactly S and values differ by at most one.
module split_samples
   import featurize_pkg::*;
#(
   parameter int SAMPLES = 15
) (
   input  logic           clk,
   input  logic           reset,
   split_samples_if.slave bus
);

   if (SAMPLES < 2 || SAMPLES > 255) begin : g_bad_samples
      $error("split_samples: SAMPLES=%0d outside 2..255", SAMPLES);
   end

   localparam int                KW      = $clog2(SAMPLES);
   localparam logic [DATA_W-1:0] DIVISOR = DATA_W'(SAMPLES);
   localparam logic [DATA_W-1:0] LAST_K  = DATA_W'(SAMPLES - 1);

   split_state_t      state;
   logic [KW-1:0]     k;
   logic [DATA_W-1:0] k_ext;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] rem;
   logic              div_busy;
   logic              div_done;
   logic              accept;
   logic              is_last;

   assign accept  = (state == IDLE) && bus.i_valid && !div_busy;
   assign k_ext   = DATA_W'(k);
   assign is_last = (k_ext == LAST_K);

   // The divider captures i_data directly on the accept edge; its result
   // registers then serve as q and r for the whole emission phase.
   restoring_div8 u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (accept),
      .dividend  (bus.i_data),
      .divisor   (DIVISOR),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rem)
   );

   // Control FSM and emission index; k only advances on an output transfer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         k     <= '0;
      end else begin
         case (state)
            IDLE: begin
               k <= '0;
               if (accept) state <= DIVIDE;
            end
            DIVIDE: begin
               if (div_done) begin
                  state <= EMIT;
                  k     <= '0;
               end
            end
            EMIT: begin
               if (bus.i_ready) begin
                  if (is_last) begin
                     state <= IDLE;
                     k     <= '0;
                  end else begin
                     k <= k + KW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               k     <= '0;
            end
         endcase
      end
   end

   // Outputs decode only registered state, so stalls cannot disturb them.
   always_comb begin
      bus.o_ready = (state == IDLE);
      bus.o_valid = (state == EMIT);
      bus.o_last  = 1'b0;
      bus.o_data  = '0;
      if (state == EMIT) begin
         bus.o_last = is_last;
         bus.o_data = (k_ext < rem) ? (quo + 8'd1) : quo;
      end
   end

endmodule

// File: tb/tb_split_samples.sv
// Self-checking bench for split_samples. The reference deals the sum out one
// unit at a time round-robin over the samples, which gives the expected
// even split without any division.
module tb_split_samples;

   localparam int N = 15;

   logic clk = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;
   int   exp_q[$];
   int   base;
   int   oidx;

   split_samples_if bus ();

   split_samples #(.SAMPLES(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: deal s units one by one over N slots, append slots to exp_q.
   function automatic void expand_push(input int s);
      int a[N];
      for (int i = 0; i < N; i++) a[i] = 0;
      for (int u = 0; u < s; u++) a[u % N]++;
      for (int i = 0; i < N; i++) exp_q.push_back(a[i]);
   endfunction

   // mode 0: i_ready always high; 1: pattern 1,0,0 repeating; 2: random.
   task automatic run_group(input int s, input int mode);
      int   cyc, idx, guard, sum, mn, mx, j;
      logic rdy;
      exp_q.delete();
      expand_push(s);
      check("idle_ready", 32'(bus.o_ready), 1);
      bus.i_data  = 8'(s);
      bus.i_valid = 1'b1;
      bus.i_ready = 1'b1;
      tick;
      bus.i_valid = 1'b0;
      check("ready_low_after_accept", 32'(bus.o_ready), 0);
      cyc = 1;
      while (bus.o_valid !== 1'b1 && cyc < 40) begin
         check("data_zero_while_busy", 32'(bus.o_data), 0);
         tick;
         cyc++;
      end
      check("first_valid_latency", cyc, 9);
      idx = 0; j = 0; sum = 0; mn = 255; mx = 0; guard = 0;
      while (idx < N && guard < 400) begin
         rdy = (mode == 0) ? 1'b1 :
               (mode == 1) ? (j % 3 == 0) : 1'($urandom_range(0, 1));
         bus.i_ready = rdy;
         check("o_valid", 32'(bus.o_valid), 1);
         check("o_data", 32'(bus.o_data), exp_q[idx]);
         check("o_last", 32'(bus.o_last), 32'(idx == N - 1));
         if (rdy) begin
            sum += int'(bus.o_data);
            if (int'(bus.o_data) < mn) mn = int'(bus.o_data);
            if (int'(bus.o_data) > mx) mx = int'(bus.o_data);
            idx++;
         end
         tick;
         cyc++; j++; guard++;
      end
      bus.i_ready = 1'b1;
      check("group_complete", idx, N);
      if (mode == 0) check("ready_return_cycles", cyc, 9 + N);
      check("ready_after", 32'(bus.o_ready), 1);
      check("valid_after", 32'(bus.o_valid), 0);
      check("data_after", 32'(bus.o_data), 0);
      check("group_sum", sum, s);
      check("spread_le1", 32'((mx - mn) <= 1), 1);
   endtask

   initial begin
      reset       = 1'b0;
      bus.i_data  = '0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      #12;
      check("rst_o_ready", 32'(bus.o_ready), 1);
      check("rst_o_valid", 32'(bus.o_valid), 0);
      check("rst_o_data", 32'(bus.o_data), 0);
      check("rst_o_last", 32'(bus.o_last), 0);
      reset = 1'b1;
      tick;
      tick;

      // Directed groups and boundaries.
      run_group(37, 0);
      run_group(0, 0);
      run_group(255, 0);
      run_group(9, 0);

      // Full sweep of sums.
      for (int s = 1; s <= 255; s++) run_group(s, 0);

      // Backpressure pattern, then random stalls on random sums.
      run_group(50, 1);
      repeat (20) run_group(int'($urandom_range(0, 255)), 2);

      // i_valid held high with incrementing data: only cycles 0, 24, 48 accept.
      base = int'($urandom_range(0, 150));
      exp_q.delete();
      for (int g = 0; g < 3; g++) expand_push(base + 24 * g);
      bus.i_ready = 1'b1;
      oidx = 0;
      for (int c = 0; c < 72; c++) begin
         bus.i_data  = 8'(base + c);
         bus.i_valid = 1'b1;
         if (bus.o_valid === 1'b1) begin
            check("stream_data", 32'(bus.o_data), (oidx < exp_q.size()) ? exp_q[oidx] : 999);
            oidx++;
         end
         tick;
      end
      bus.i_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (bus.o_valid === 1'b1) begin
            check("stream_extra_data", 32'(bus.o_data), 999);
            oidx++;
         end
         tick;
      end
      check("stream_count", oidx, 3 * N);
      check("stream_idle_after", 32'(bus.o_ready), 1);

      // Reset in the middle of emitting S=100, then a clean S=30 group.
      exp_q.delete();
      expand_push(100);
      bus.i_data  = 8'd100;
      bus.i_valid = 1'b1;
      bus.i_ready = 1'b1;
      tick;
      bus.i_valid = 1'b0;
      repeat (8) tick;
      for (int i = 0; i < 6; i++) begin
         check("pre_reset_data", 32'(bus.o_data), exp_q[i]);
         tick;
      end
      check("pre_reset_valid", 32'(bus.o_valid), 1);
      #2 reset = 1'b0;
      #1;
      check("midrst_o_ready", 32'(bus.o_ready), 1);
      check("midrst_o_valid", 32'(bus.o_valid), 0);
      check("midrst_o_data", 32'(bus.o_data), 0);
      check("midrst_o_last", 32'(bus.o_last), 0);
      tick;
      check("midrst_hold_valid", 32'(bus.o_valid), 0);
      #3 reset = 1'b1;
      tick;
      check("post_rst_valid", 32'(bus.o_valid), 0);
      run_group(30, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
